// File: rtl/fv_bank_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fv_bank_req_arbiter
// Brief   : Shares one Big FV bank controller between NUM_PE Edge PE readers
//           and one write-back source. Issues single-cycle read packets or
//           gap-free write-back bursts. Reads rotate round-robin, and
//           write-back has priority for at most WB_STREAK_MAX bursts in a row
//           while reads are waiting.
// Revision: 1.0  initial release
// ============================================================================
module fv_bank_req_arbiter #(
  parameter int NUM_PE        = 4,
  parameter int NODE_W        = 8,
  parameter int DATA_W        = 64,
  parameter int WB_STREAK_MAX = 3,
  localparam int c_tag_w      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     update_phase,
  input  logic                     bank_available,
  input  logic                     rd_done,
  input  logic [NUM_PE-1:0]        rd_req,
  input  logic [NUM_PE*NODE_W-1:0] rd_node_id,
  output logic [NUM_PE-1:0]        rd_ack,
  input  logic                     wb_req,
  input  logic [NODE_W-1:0]        wb_node_id,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_eos,
  output logic                     wb_ready,
  output logic                     req_valid,
  output logic                     req_rd_wr,
  output logic                     req_wr_eos,
  output logic [NODE_W-1:0]        req_node_id,
  output logic [c_tag_w-1:0]       req_pe_tag,
  output logic [DATA_W-1:0]        req_data,
  output logic                     busy,
  output logic                     wb_underrun
);

  localparam int c_streak_w = (WB_STREAK_MAX > 0) ? $clog2(WB_STREAK_MAX + 1) : 1;
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(WB_STREAK_MAX);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RD_WAIT   = 2'd1,
    S_WB_STREAM = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_tag_w-1:0]    r_rr_ptr;
  logic [c_streak_w-1:0] r_streak;
  logic                  r_rd_seen;   // a read was waiting at some point in the open burst

  logic                  r_req_valid;
  logic                  r_req_rd_wr;
  logic                  r_req_wr_eos;
  logic [NODE_W-1:0]     r_req_node_id;
  logic [c_tag_w-1:0]    r_req_pe_tag;
  logic [DATA_W-1:0]     r_req_data;
  logic [NUM_PE-1:0]     r_rd_ack;
  logic                  r_wb_underrun;

  logic                  w_any_rd;
  logic                  w_issue;
  logic                  w_grant_wr;
  logic                  w_rd_found;
  logic [c_tag_w-1:0]    w_rd_sel;
  logic [c_tag_w-1:0]    w_idx;
  logic [NODE_W-1:0]     w_rd_node;
  logic                  w_rd_pending;
  logic [c_streak_w-1:0] w_streak_next;

  assign w_any_rd = |rd_req;

  // A decision happens only from IDLE with the bank free and not streaming.
  assign w_issue = (r_state == S_IDLE) && !update_phase && bank_available &&
                   (w_any_rd || wb_req);

  // Write wins unless reads have already waited through WB_STREAK_MAX bursts.
  assign w_grant_wr = wb_req && (!w_any_rd || (r_streak < c_streak_max));

  // Round-robin search: first requesting PE at or above rr_ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    w_rd_found = 1'b0;
    w_rd_sel   = '0;
    w_idx      = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      w_idx = r_rr_ptr + c_tag_w'(k);
      if (rd_req[w_idx]) begin
        w_rd_found = 1'b1;
        w_rd_sel   = w_idx;
      end
    end
  end

  assign w_rd_node = rd_node_id[int'(w_rd_sel)*NODE_W +: NODE_W];

  // Streak bookkeeping applied when a burst closes.
  assign w_rd_pending  = w_any_rd || ((r_state == S_WB_STREAM) && r_rd_seen);
  assign w_streak_next = !w_rd_pending            ? '0 :
                         (r_streak == c_streak_max) ? c_streak_max :
                                                      r_streak + c_streak_w'(1);

  // Write-back handshake is open on a write decision and for the whole burst.
  assign wb_ready = !reset &&
                    ((w_issue && w_grant_wr) || (r_state == S_WB_STREAM));
  assign busy     = (r_state != S_IDLE);

  // Arbitration FSM with registered packet, ack and underrun outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_streak      <= '0;
      r_rd_seen     <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_rd_wr   <= 1'b0;
      r_req_wr_eos  <= 1'b0;
      r_req_node_id <= '0;
      r_req_pe_tag  <= '0;
      r_req_data    <= '0;
      r_rd_ack      <= '0;
      r_wb_underrun <= 1'b0;
    end else begin
      // Packet fields idle at zero unless something issues this cycle.
      r_req_valid   <= 1'b0;
      r_req_rd_wr   <= 1'b0;
      r_req_wr_eos  <= 1'b0;
      r_req_node_id <= '0;
      r_req_pe_tag  <= '0;
      r_req_data    <= '0;
      r_rd_ack      <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            if (w_grant_wr) begin
              r_req_valid   <= 1'b1;
              r_req_rd_wr   <= 1'b1;
              r_req_wr_eos  <= wb_eos;
              r_req_node_id <= wb_node_id;
              r_req_data    <= wb_data;
              r_rd_seen     <= w_any_rd;
              if (wb_eos) begin
                r_streak <= w_streak_next;
              end else begin
                r_state <= S_WB_STREAM;
              end
            end else if (w_rd_found) begin
              r_req_valid        <= 1'b1;
              r_req_node_id      <= w_rd_node;
              r_req_pe_tag       <= w_rd_sel;
              r_rd_ack[w_rd_sel] <= 1'b1;
              r_rr_ptr           <= w_rd_sel + c_tag_w'(1);
              r_streak           <= '0;
              r_state            <= S_RD_WAIT;
            end
          end
        end

        S_RD_WAIT: begin
          if (rd_done) begin
            r_state <= S_IDLE;
          end
        end

        S_WB_STREAM: begin
          if (wb_req) begin
            r_req_valid   <= 1'b1;
            r_req_rd_wr   <= 1'b1;
            r_req_wr_eos  <= wb_eos;
            r_req_node_id <= wb_node_id;
            r_req_data    <= wb_data;
            r_rd_seen     <= r_rd_seen || w_any_rd;
            if (wb_eos) begin
              r_streak <= w_streak_next;
              r_state  <= S_IDLE;
            end
          end else begin
            // Source stalled inside an open burst: flag it and leave a gap.
            r_wb_underrun <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_valid   = r_req_valid;
  assign req_rd_wr   = r_req_rd_wr;
  assign req_wr_eos  = r_req_wr_eos;
  assign req_node_id = r_req_node_id;
  assign req_pe_tag  = r_req_pe_tag;
  assign req_data    = r_req_data;
  assign rd_ack      = r_rd_ack;
  assign wb_underrun = r_wb_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fv_bank_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fv_bank_req_arbiter
// Brief   : Directed self-checking bench for fv_bank_req_arbiter.
// Revision: 1.0  initial release
// ============================================================================
module tb_fv_bank_req_arbiter;

  logic        clk;
  logic        reset;
  logic        update_phase;
  logic        bank_available;
  logic        rd_done;
  logic [3:0]  rd_req;
  logic [31:0] rd_node_id;
  logic [3:0]  rd_ack;
  logic        wb_req;
  logic [7:0]  wb_node_id;
  logic [63:0] wb_data;
  logic        wb_eos;
  logic        wb_ready;
  logic        req_valid;
  logic        req_rd_wr;
  logic        req_wr_eos;
  logic [7:0]  req_node_id;
  logic [1:0]  req_pe_tag;
  logic [63:0] req_data;
  logic        busy;
  logic        wb_underrun;

  int checks;
  int failures;

  fv_bank_req_arbiter #(
    .NUM_PE(4), .NODE_W(8), .DATA_W(64), .WB_STREAK_MAX(3)
  ) dut (
    .clk(clk), .reset(reset), .update_phase(update_phase),
    .bank_available(bank_available), .rd_done(rd_done),
    .rd_req(rd_req), .rd_node_id(rd_node_id), .rd_ack(rd_ack),
    .wb_req(wb_req), .wb_node_id(wb_node_id), .wb_data(wb_data),
    .wb_eos(wb_eos), .wb_ready(wb_ready),
    .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_wr_eos(req_wr_eos),
    .req_node_id(req_node_id), .req_pe_tag(req_pe_tag), .req_data(req_data),
    .busy(busy), .wb_underrun(wb_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    update_phase = 1'b0; bank_available = 1'b1; rd_done = 1'b0; rd_req = 4'b0;
    wb_req = 1'b0; wb_eos = 1'b0; wb_data = 64'h0; wb_node_id = 8'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_req = 4'hF; wb_req = 1'b1; wb_eos = 1'b0; bank_available = 1'b1; update_phase = 1'b0;
    tick(); tick();
    checks++; if ({req_valid, req_rd_wr, req_wr_eos, req_node_id, req_pe_tag, req_data, rd_ack} !== '0) begin
      failures++; $display("FAIL reset_pkt: got valid=%b node=%h data=%h ack=%b, required all 0", req_valid, req_node_id, req_data, rd_ack); end
    checks++; if ({wb_ready, busy, wb_underrun} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl: got ready/busy/underrun=%b, required 000", {wb_ready, busy, wb_underrun}); end
    reset_dut();
  endtask

  task automatic test_single_read();
    reset_dut();
    rd_req = 4'b0100;
    tick();
    checks++; if ({req_valid, req_rd_wr, req_wr_eos} !== 3'b100) begin
      failures++; $display("FAIL rd_pkt_flags: got %b required 100", {req_valid, req_rd_wr, req_wr_eos}); end
    checks++; if (req_node_id !== 8'h15 || req_pe_tag !== 2'd2 || req_data !== 64'h0) begin
      failures++; $display("FAIL rd_pkt_fields: got node=%h tag=%0d data=%h required 15/2/0", req_node_id, req_pe_tag, req_data); end
    checks++; if (rd_ack !== 4'b0100 || busy !== 1'b1) begin
      failures++; $display("FAIL rd_ack: got ack=%b busy=%b required 0100/1", rd_ack, busy); end
    rd_req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({req_valid, rd_ack, busy} !== 6'b000001) begin
        failures++; $display("FAIL rd_wait_hold: got valid=%b ack=%b busy=%b required 0/0000/1", req_valid, rd_ack, busy); end
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin
      failures++; $display("FAIL rd_done_idle: got busy=%b valid=%b required 0/0", busy, req_valid); end
    tick();
    checks++; if (req_valid !== 1'b1 || req_pe_tag !== 2'd0 || rd_ack !== 4'b0001) begin
      failures++; $display("FAIL rd_next_issue: got valid=%b tag=%0d ack=%b required 1/0/0001", req_valid, req_pe_tag, rd_ack); end
    rd_req = 4'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_tag [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_node [4] = '{8'h11, 8'h22, 8'h15, 8'h44};
    logic [3:0] exp_ack;
    reset_dut();
    rd_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      int waited;
      waited = 0;
      tick();
      while (!req_valid && waited < 10) begin tick(); waited++; end
      exp_ack = 4'b0001 << exp_tag[i];
      checks++; if (req_valid !== 1'b1 || req_pe_tag !== 2'(exp_tag[i])) begin
        failures++; $display("FAIL rr_order[%0d]: got valid=%b tag=%0d required 1/%0d", i, req_valid, req_pe_tag, exp_tag[i]); end
      checks++; if (rd_ack !== exp_ack || req_node_id !== exp_node[exp_tag[i]]) begin
        failures++; $display("FAIL rr_ack[%0d]: got ack=%b node=%h required %b/%h", i, rd_ack, req_node_id, exp_ack, exp_node[exp_tag[i]]); end
      tick(); tick();
      rd_done = 1'b1; tick(); rd_done = 1'b0;
    end
    rd_req = 4'b0;
  endtask

  task automatic test_write_burst();
    reset_dut();
    wb_node_id = 8'h08; wb_req = 1'b1; wb_data = 64'hA0; wb_eos = 1'b0;
    #1;
    checks++; if (wb_ready !== 1'b1) begin
      failures++; $display("FAIL wb_ready_decide: got %b required 1", wb_ready); end
    for (int b = 0; b < 4; b++) begin
      wb_data = 64'hA0 + 64'(b);
      wb_eos  = (b == 3);
      tick();
      if (b == 3) begin wb_req = 1'b0; wb_eos = 1'b0; end
      checks++; if ({req_valid, req_rd_wr, req_wr_eos} !== {2'b11, (b == 3)} || req_data !== 64'hA0 + 64'(b)) begin
        failures++; $display("FAIL wb_beat[%0d]: got v/rw/eos=%b data=%h required %b/%h", b, {req_valid, req_rd_wr, req_wr_eos}, req_data, {2'b11, (b == 3)}, 64'hA0 + 64'(b)); end
      checks++; if (req_node_id !== 8'h08 || req_pe_tag !== 2'd0 || busy !== (b != 3)) begin
        failures++; $display("FAIL wb_beat_ctl[%0d]: got node=%h tag=%0d busy=%b required 08/0/%b", b, req_node_id, req_pe_tag, busy, (b != 3)); end
    end
    tick();
    checks++; if (req_valid !== 1'b0 || req_data !== 64'h0) begin
      failures++; $display("FAIL wb_after_eos: got valid=%b data=%h required 0/0", req_valid, req_data); end
    wb_req = 1'b1; wb_data = 64'h5A; wb_eos = 1'b1;
    tick();
    wb_req = 1'b0; wb_eos = 1'b0;
    checks++; if ({req_valid, req_wr_eos, busy} !== 3'b110 || req_data !== 64'h5A) begin
      failures++; $display("FAIL wb_single: got v/eos/busy=%b data=%h required 110/5a", {req_valid, req_wr_eos, busy}, req_data); end
    tick();
    checks++; if (req_valid !== 1'b0) begin
      failures++; $display("FAIL wb_single_end: got valid=%b required 0", req_valid); end
  endtask

  task automatic test_starvation();
    logic kind [5];
    logic exp_kind [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;
    int done_cd;
    n = 0; done_cd = 0;
    reset_dut();
    rd_req = 4'b0001; wb_req = 1'b1; wb_eos = 1'b1; wb_node_id = 8'h40; wb_data = 64'h100;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      tick();
      if (rd_done) rd_done = 1'b0;
      if (done_cd > 0) begin done_cd--; if (done_cd == 0) rd_done = 1'b1; end
      if (req_valid) begin
        kind[n] = req_rd_wr;
        n++;
        if (!req_rd_wr) begin rd_req = 4'b0; done_cd = 2; end
      end
      wb_data = wb_data + 64'h1;
    end
    wb_req = 1'b0; wb_eos = 1'b0; rd_done = 1'b0;
    checks++; if (n !== 5) begin
      failures++; $display("FAIL starve_count: got %0d packets required 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (kind[i] !== exp_kind[i]) begin
        failures++; $display("FAIL starve_seq[%0d]: got rd_wr=%b required %b", i, kind[i], exp_kind[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_gating();
    reset_dut();
    update_phase = 1'b1; rd_req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({req_valid, rd_ack, busy} !== 6'b0) begin
        failures++; $display("FAIL gate_update: got valid=%b ack=%b busy=%b required 0", req_valid, rd_ack, busy); end
    end
    update_phase = 1'b0; bank_available = 1'b0; wb_req = 1'b1; wb_eos = 1'b1;
    #1;
    checks++; if (wb_ready !== 1'b0) begin
      failures++; $display("FAIL gate_wb_ready: got %b required 0", wb_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({req_valid, rd_ack} !== 5'b0) begin
        failures++; $display("FAIL gate_bank: got valid=%b ack=%b required 0", req_valid, rd_ack); end
    end
    wb_req = 1'b0; wb_eos = 1'b0; bank_available = 1'b1;
    tick();
    checks++; if (req_valid !== 1'b1 || req_pe_tag !== 2'd1 || rd_ack !== 4'b0010) begin
      failures++; $display("FAIL gate_open: got valid=%b tag=%0d ack=%b required 1/1/0010", req_valid, req_pe_tag, rd_ack); end
    rd_req = 4'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  task automatic test_underrun_reset();
    reset_dut();
    rd_req = 4'b0100;
    tick();
    rd_req = 4'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    wb_req = 1'b1; wb_node_id = 8'h08; wb_eos = 1'b0; wb_data = 64'hB0;
    tick();
    wb_data = 64'hB1;
    tick();
    wb_req = 1'b0;
    tick();
    checks++; if ({wb_underrun, req_valid, busy} !== 3'b101) begin
      failures++; $display("FAIL underrun_gap: got underrun/valid/busy=%b required 101", {wb_underrun, req_valid, busy}); end
    wb_req = 1'b1; wb_data = 64'hB2;
    tick();
    checks++; if (req_valid !== 1'b1 || req_data !== 64'hB2 || wb_underrun !== 1'b1) begin
      failures++; $display("FAIL underrun_resume: got valid=%b data=%h underrun=%b required 1/b2/1", req_valid, req_data, wb_underrun); end
    rd_req = 4'hF;
    reset = 1'b1;
    #1;
    checks++; if ({req_valid, req_rd_wr, req_wr_eos, req_node_id, req_pe_tag, req_data, rd_ack} !== '0) begin
      failures++; $display("FAIL reset_mid_pkt: got valid=%b data=%h ack=%b required all 0", req_valid, req_data, rd_ack); end
    checks++; if ({wb_ready, busy, wb_underrun} !== 3'b000) begin
      failures++; $display("FAIL reset_mid_ctl: got ready/busy/underrun=%b required 000", {wb_ready, busy, wb_underrun}); end
    tick();
    reset = 1'b0; wb_req = 1'b0;
    tick();
    checks++; if (req_valid !== 1'b1 || req_pe_tag !== 2'd0 || rd_ack !== 4'b0001) begin
      failures++; $display("FAIL reset_rr_ptr: got valid=%b tag=%0d ack=%b required 1/0/0001", req_valid, req_pe_tag, rd_ack); end
    rd_req = 4'b0;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; update_phase = 1'b0; bank_available = 1'b1; rd_done = 1'b0;
    rd_req = 4'b0; wb_req = 1'b0; wb_eos = 1'b0; wb_data = 64'h0; wb_node_id = 8'h0;
    rd_node_id = {8'h44, 8'h15, 8'h22, 8'h11};
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_starvation();
    test_gating();
    test_underrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
